// File: rtl/int_float_convert.sv
// rtl/int_float_convert.sv - registered signed integer to IEEE-754 converter
// Also reports the leading-one position of |a| and the remainder below it.
module int_float_convert #(
  parameter int WIDTH = 32,
  localparam int EXP_W = (WIDTH == 64) ? 11 : 8,
  localparam int MAN_W = (WIDTH == 64) ? 52 : 23,
  localparam int BIAS  = (WIDTH == 64) ? 1023 : 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [WIDTH-1:0] b,
  output logic [EXP_W-1:0] pow,
  output logic [WIDTH-1:0] rem
);

  logic             s;
  logic [WIDTH-1:0] mag;
  logic [EXP_W-1:0] p;
  logic [WIDTH-1:0] rem_c;
  logic [MAN_W-1:0] man;
  logic [EXP_W-1:0] expo;

  always_comb begin
    s   = a[WIDTH-1];
    mag = s ? -a : a;

    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) p = EXP_W'(i);
    end

    rem_c = mag & ~(WIDTH'(1) << p);

    // Wide magnitudes drop low bits: plain truncation, so no rounding carry.
    if (p <= EXP_W'(MAN_W))
      man = MAN_W'(rem_c << (EXP_W'(MAN_W) - p));
    else
      man = MAN_W'(rem_c >> (p - EXP_W'(MAN_W)));

    expo = (mag == '0) ? '0 : p + EXP_W'(BIAS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      b         <= '0;
      pow       <= '0;
      rem       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        b   <= {s, expo, man};
        pow <= p;
        rem <= rem_c;
      end
    end
  end

endmodule

// File: tb/tb_int_float_convert.sv
// tb/tb_int_float_convert.sv - directed vector bench for int_float_convert
// Runs a binary32 and a binary64 instance side by side on one clock.
module tb_int_float_convert;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv32 = 1'b0;
  logic [31:0] a32 = '0;
  logic        ov32;
  logic [31:0] b32;
  logic [7:0]  pow32;
  logic [31:0] rem32;
  logic        iv64 = 1'b0;
  logic [63:0] a64 = '0;
  logic        ov64;
  logic [63:0] b64;
  logic [10:0] pow64;
  logic [63:0] rem64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_float_convert #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .a(a32),
    .out_valid(ov32), .b(b32), .pow(pow32), .rem(rem32)
  );

  int_float_convert #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .a(a64),
    .out_valid(ov64), .b(b64), .pow(pow64), .rem(rem64)
  );

  typedef struct {
    logic        iv;
    logic [31:0] a;
    logic        ov;
    logic [31:0] b;
    logic [7:0]  pow;
    logic [31:0] rem;
  } vec32_t;

  vec32_t tbl[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic ov, input logic [31:0] eb,
                       input logic [7:0] ep, input logic [31:0] er);
    chk({name, ".out_valid"}, 64'(ov32), 64'(ov));
    chk({name, ".b"}, 64'(b32), 64'(eb));
    chk({name, ".pow"}, 64'(pow32), 64'(ep));
    chk({name, ".rem"}, 64'(rem32), 64'(er));
  endtask

  task automatic chk64(input string name, input logic ov, input logic [63:0] eb,
                       input logic [10:0] ep, input logic [63:0] er);
    chk({name, ".out_valid"}, 64'(ov64), 64'(ov));
    chk({name, ".b"}, b64, eb);
    chk({name, ".pow"}, 64'(pow64), 64'(ep));
    chk({name, ".rem"}, rem64, er);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'd0,          1'b1, 32'h00000000, 8'd0,  32'd0};
    tbl[1]  = '{1'b1, 32'd1,          1'b1, 32'h3F800000, 8'd0,  32'd0};
    tbl[2]  = '{1'b1, 32'd2,          1'b1, 32'h40000000, 8'd1,  32'd0};
    tbl[3]  = '{1'b1, 32'd3,          1'b1, 32'h40400000, 8'd1,  32'd1};
    tbl[4]  = '{1'b1, 32'd4,          1'b1, 32'h40800000, 8'd2,  32'd0};
    tbl[5]  = '{1'b1, 32'd5,          1'b1, 32'h40A00000, 8'd2,  32'd1};
    tbl[6]  = '{1'b1, 32'd6,          1'b1, 32'h40C00000, 8'd2,  32'd2};
    tbl[7]  = '{1'b1, 32'd7,          1'b1, 32'h40E00000, 8'd2,  32'd3};
    tbl[8]  = '{1'b1, 32'd8,          1'b1, 32'h41000000, 8'd3,  32'd0};
    tbl[9]  = '{1'b1, 32'd9,          1'b1, 32'h41100000, 8'd3,  32'd1};
    tbl[10] = '{1'b0, 32'd77,         1'b0, 32'h41100000, 8'd3,  32'd1};
    tbl[11] = '{1'b1, 32'hFFFFFFFF,   1'b1, 32'hBF800000, 8'd0,  32'd0};
    tbl[12] = '{1'b1, 32'hFFFFFFFB,   1'b1, 32'hC0A00000, 8'd2,  32'd1};
    tbl[13] = '{1'b1, 32'hFFFFFFF8,   1'b1, 32'hC1000000, 8'd3,  32'd0};
    tbl[14] = '{1'b1, 32'h80000000,   1'b1, 32'hCF000000, 8'd31, 32'd0};
    tbl[15] = '{1'b1, 32'd300158478,  1'b1, {1'b0, 8'd155, 23'd991344}, 8'd28, 32'd31723022};
    tbl[16] = '{1'b1, 32'h7FFFFFFF,   1'b1, 32'h4EFFFFFF, 8'd30, 32'h3FFFFFFF};
    tbl[17] = '{1'b1, 32'd8388609,    1'b1, 32'h4B000001, 8'd23, 32'd1};
    tbl[18] = '{1'b1, 32'd16777217,   1'b1, 32'h4B800000, 8'd24, 32'd1};
    tbl[19] = '{1'b0, 32'hFFFFFFFB,   1'b0, 32'h4B800000, 8'd24, 32'd1};
    tbl[20] = '{1'b1, 32'd80,         1'b1, 32'h42A00000, 8'd6,  32'd16};

    // Reset held with a live input: outputs stay cleared.
    rst = 1'b1; iv32 = 1'b1; a32 = 32'd80; iv64 = 1'b1; a64 = 64'd80;
    repeat (2) @(posedge clk);
    #1;
    chk32("reset_held", 1'b0, 32'h0, 8'd0, 32'd0);
    chk64("reset_held64", 1'b0, 64'h0, 11'd0, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk32("reset_released", 1'b0, 32'h0, 8'd0, 32'd0);

    // First result one cycle after release.
    @(posedge clk); #1;
    chk32("a80_first", 1'b1, 32'h42A00000, 8'd6, 32'd16);
    iv64 = 1'b0;

    // Table: one vector per cycle, streamed back to back.
    for (int i = 0; i < 21; i++) begin
      iv32 = tbl[i].iv;
      a32  = tbl[i].a;
      @(posedge clk); #1;
      chk32($sformatf("vec%0d", i), tbl[i].ov, tbl[i].b, tbl[i].pow, tbl[i].rem);
    end

    // Asynchronous reset mid-stream clears immediately and drops the next input.
    iv32 = 1'b1; a32 = 32'hFFFFFFFB;
    #2 rst = 1'b1;
    #1;
    chk32("async_reset", 1'b0, 32'h0, 8'd0, 32'd0);
    @(posedge clk); #1;
    chk32("reset_discard", 1'b0, 32'h0, 8'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0; iv32 = 1'b0;

    // binary64 with in_valid toggling.
    iv64 = 1'b1; a64 = 64'd80;
    @(posedge clk); #1;
    chk64("w64_a80", 1'b1, 64'h4054000000000000, 11'd6, 64'd16);
    iv64 = 1'b0; a64 = -64'sd5;
    @(posedge clk); #1;
    chk64("w64_hold", 1'b0, 64'h4054000000000000, 11'd6, 64'd16);
    iv64 = 1'b1;
    @(posedge clk); #1;
    chk64("w64_m5", 1'b1, 64'hC014000000000000, 11'd2, 64'd1);
    iv64 = 1'b0; a64 = 64'h8000000000000000;
    @(posedge clk); #1;
    chk64("w64_hold2", 1'b0, 64'hC014000000000000, 11'd2, 64'd1);
    iv64 = 1'b1;
    @(posedge clk); #1;
    chk64("w64_min", 1'b1, 64'hC3E0000000000000, 11'd63, 64'd0);
    a64 = 64'h7FFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    chk64("w64_max", 1'b1, 64'h43DFFFFFFFFFFFFF, 11'd62, 64'h3FFFFFFFFFFFFFFF);
    iv64 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
